// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcode values, ALU encodings, GPR widths and the ID/EX entry type.
package id_stage_pkg;
  localparam int GPR_WIDTH = 32;
  localparam int GPR_ADDR_SPACE = 5;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic [GPR_WIDTH-1:0]      rs1_val;
    logic [GPR_WIDTH-1:0]      rs2_val;
    logic [31:0]               imm;
    logic [GPR_ADDR_SPACE-1:0] rd;
    logic                      rd_we;
    logic [2:0]                funct3;
    alu_op_e                   alu_op;
    logic                      alu_src;
    logic                      mem_re;
    logic                      mem_we;
    logic                      illegal;
  } id_ex_t;
  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    alu_dec = alt ? ALU_SUB : ALU_ADD;
    case (f3)
      3'd1: alu_dec = ALU_SLL;
      3'd2: alu_dec = ALU_SLT;
      3'd3: alu_dec = ALU_SLTU;
      3'd4: alu_dec = ALU_XOR;
      3'd5: alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'd6: alu_dec = ALU_OR;
      3'd7: alu_dec = ALU_AND;
      default: ;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: RV32I sign-extended immediate by opcode format; R-type and unknown give 0.
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
      OPC_JAL: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default: ;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode with WB bypass, load-use interlock and registered ID/EX outputs.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inst_valid_i,
  input  logic [31:0]               inst_i,
  input  logic [31:0]               pc_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [GPR_ADDR_SPACE-1:0] rs1_addr_o,
  output logic [GPR_ADDR_SPACE-1:0] rs2_addr_o,
  input  logic [GPR_WIDTH-1:0]      rs1_val_i,
  input  logic [GPR_WIDTH-1:0]      rs2_val_i,
  input  logic                      wb_we_i,
  input  logic [GPR_ADDR_SPACE-1:0] wb_rd_addr_i,
  input  logic [GPR_WIDTH-1:0]      wb_rd_val_i,
  output logic                      stall_o,
  output logic                      id_valid_o,
  output logic [31:0]               pc_o,
  output logic [GPR_WIDTH-1:0]      rs1_val_o,
  output logic [GPR_WIDTH-1:0]      rs2_val_o,
  output logic [31:0]               imm_o,
  output logic [GPR_ADDR_SPACE-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [2:0]                funct3_o,
  output logic [3:0]                alu_op_o,
  output logic                      alu_src_o,
  output logic                      mem_re_o,
  output logic                      mem_we_o,
  output logic                      illegal_o
);
  id_ex_t ex_q, ex_d, dec;
  logic [31:0] imm;
  logic use1, use2, hazard;
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];
  imm_gen u_imm_gen (.inst(inst_i), .imm(imm));
  function automatic logic [GPR_WIDTH-1:0] fwd(input logic [GPR_ADDR_SPACE-1:0] a, input logic [GPR_WIDTH-1:0] v);
    return (a == '0) ? '0 : (wb_we_i && wb_rd_addr_i == a) ? wb_rd_val_i : v;
  endfunction
  always_comb begin
    dec = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    dec.valid = 1'b1;
    dec.pc = pc_i;
    dec.rs1_val = fwd(rs1_addr_o, rs1_val_i);
    dec.rs2_val = fwd(rs2_addr_o, rs2_val_i);
    dec.imm = imm;
    dec.rd = inst_i[11:7];
    dec.funct3 = inst_i[14:12];
    case (inst_i[6:0])
      OPC_LUI: begin dec.rd_we = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_PASSB; end
      OPC_AUIPC, OPC_JAL: begin dec.rd_we = 1'b1; dec.alu_src = 1'b1; end
      OPC_JALR: begin dec.rd_we = 1'b1; dec.alu_src = 1'b1; use1 = 1'b1; end
      OPC_BRANCH: begin use1 = 1'b1; use2 = 1'b1; end
      OPC_LOAD: begin dec.rd_we = 1'b1; dec.alu_src = 1'b1; dec.mem_re = 1'b1; use1 = 1'b1; end
      OPC_STORE: begin dec.alu_src = 1'b1; dec.mem_we = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OPC_OPIMM: begin
        dec.rd_we = 1'b1;
        dec.alu_src = 1'b1;
        use1 = 1'b1;
        dec.alu_op = alu_dec(inst_i[14:12], inst_i[30] && inst_i[14:12] == 3'd5);
      end
      OPC_OP: begin
        dec.rd_we = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
        dec.alu_op = alu_dec(inst_i[14:12], inst_i[30]);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_we = dec.rd_we && dec.rd != '0;
    // a load in EX whose result this instruction reads cannot be bypassed yet
    hazard = ex_q.valid && ex_q.mem_re && ex_q.rd != '0 && inst_valid_i &&
             ((use1 && ex_q.rd == rs1_addr_o) || (use2 && ex_q.rd == rs2_addr_o));
    stall_o = hazard && !flush_i && !stall_i;
    ex_d = flush_i ? '0 : stall_i ? ex_q : (hazard || !inst_valid_i) ? '0 : dec;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ex_q <= '0;
    else ex_q <= ex_d;
  assign id_valid_o = ex_q.valid;
  assign pc_o = ex_q.pc;
  assign rs1_val_o = ex_q.rs1_val;
  assign rs2_val_o = ex_q.rs2_val;
  assign imm_o = ex_q.imm;
  assign rd_addr_o = ex_q.rd;
  assign rd_we_o = ex_q.rd_we;
  assign funct3_o = ex_q.funct3;
  assign alu_op_o = ex_q.alu_op;
  assign alu_src_o = ex_q.alu_src;
  assign mem_re_o = ex_q.mem_re;
  assign mem_we_o = ex_q.mem_we;
  assign illegal_o = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random stimulus against a format-table reference model of id_stage.
module tb_id_stage;
  import id_stage_pkg::*;
  typedef struct {
    logic v, we, re, mw, ill, src;
    logic [31:0] pc, a, b, imm;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [3:0] alu;
  } ent_t;
  logic clk = 0, rst = 1;
  logic inst_valid, stall, flush, wb_we, stall_o, id_valid, rd_we, alu_src, mem_re, mem_we, illegal;
  logic [31:0] inst, pc, rs1_val, rs2_val, wb_val, pc_o, rs1_val_o, rs2_val_o, imm_o, snap_pc, snap_imm;
  logic [4:0] rs1_addr, rs2_addr, wb_addr, rd_addr;
  logic [2:0] funct3;
  logic [3:0] alu_op;
  int n_chk = 0, n_fail = 0;
  ent_t mdl;
  logic st_seen;
  always #5 clk = ~clk;

  id_stage dut (
    .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .inst_i(inst), .pc_i(pc),
    .stall_i(stall), .flush_i(flush), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .rs1_val_i(rs1_val), .rs2_val_i(rs2_val), .wb_we_i(wb_we), .wb_rd_addr_i(wb_addr),
    .wb_rd_val_i(wb_val), .stall_o(stall_o), .id_valid_o(id_valid), .pc_o(pc_o),
    .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o), .imm_o(imm_o), .rd_addr_o(rd_addr),
    .rd_we_o(rd_we), .funct3_o(funct3), .alu_op_o(alu_op), .alu_src_o(alu_src),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .illegal_o(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic ent_t bubble(input ent_t e);
    bubble = e;
    bubble.v = 0; bubble.we = 0; bubble.re = 0; bubble.mw = 0; bubble.ill = 0;
  endfunction

  // reference decode straight from the RV32I format table
  function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] p, v1, v2,
                                   input logic wwe, input logic [4:0] wa, input logic [31:0] wv,
                                   output logic u1, output logic u2);
    ent_t e;
    byte f;
    logic signed [11:0] si, ss;
    logic signed [12:0] sb;
    logic signed [20:0] sj;
    logic [3:0] tab [8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    e = '{default: 0};
    e.v = 1; e.pc = p; e.rd = i[11:7]; e.f3 = i[14:12];
    e.a = (i[19:15] == 0) ? 0 : (wwe && wa == i[19:15]) ? wv : v1;
    e.b = (i[24:20] == 0) ? 0 : (wwe && wa == i[24:20]) ? wv : v2;
    e.alu = ALU_ADD;
    f = "X";
    case (i[6:0])
      7'h37: begin f = "U"; e.we = 1; e.src = 1; e.alu = ALU_PASSB; end
      7'h17: begin f = "U"; e.we = 1; e.src = 1; end
      7'h6F: begin f = "J"; e.we = 1; e.src = 1; end
      7'h67: begin f = "I"; e.we = 1; e.src = 1; end
      7'h63: f = "B";
      7'h03: begin f = "I"; e.we = 1; e.src = 1; e.re = 1; end
      7'h23: begin f = "S"; e.src = 1; e.mw = 1; end
      7'h13: begin f = "I"; e.we = 1; e.src = 1; e.alu = tab[i[14:12]]; end
      7'h33: begin f = "R"; e.we = 1; e.alu = tab[i[14:12]]; end
      default: e.ill = 1;
    endcase
    if (i[6:0] == 7'h33 && i[14:12] == 0 && i[30]) e.alu = ALU_SUB;
    if ((i[6:0] == 7'h33 || i[6:0] == 7'h13) && i[14:12] == 5 && i[30]) e.alu = ALU_SRA;
    si = i[31:20];
    ss = {i[31:25], i[11:7]};
    sb = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    sj = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    e.imm = (f == "I") ? 32'(si) : (f == "S") ? 32'(ss) : (f == "B") ? 32'(sb) :
            (f == "J") ? 32'(sj) : (f == "U") ? {i[31:12], 12'h000} : 0;
    if (e.rd == 0) e.we = 0;
    u1 = (f == "I" || f == "S" || f == "B" || f == "R");
    u2 = (f == "S" || f == "B" || f == "R");
    return e;
  endfunction

  task automatic cmp_out();
    check("id_valid", 32'(id_valid), 32'(mdl.v));
    check("illegal", 32'(illegal), 32'(mdl.ill));
    check("rd_we", 32'(rd_we), 32'(mdl.we));
    check("mem_re", 32'(mem_re), 32'(mdl.re));
    check("mem_we", 32'(mem_we), 32'(mdl.mw));
    if (mdl.v && !mdl.ill) begin
      check("pc", pc_o, mdl.pc);
      check("rs1_val", rs1_val_o, mdl.a);
      check("rs2_val", rs2_val_o, mdl.b);
      check("imm", imm_o, mdl.imm);
      check("rd_addr", 32'(rd_addr), 32'(mdl.rd));
      check("funct3", 32'(funct3), 32'(mdl.f3));
      check("alu_op", 32'(alu_op), 32'(mdl.alu));
      check("alu_src", 32'(alu_src), 32'(mdl.src));
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic iv, stl, fl, input logic [31:0] v1, v2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wv, input logic [31:0] p);
    ent_t d;
    logic u1, u2, haz;
    @(negedge clk);
    inst = ins; inst_valid = iv; stall = stl; flush = fl; rs1_val = v1; rs2_val = v2;
    wb_we = we; wb_addr = wa; wb_val = wv; pc = p;
    #1;
    d = ref_dec(ins, p, v1, v2, we, wa, wv, u1, u2);
    haz = mdl.v && mdl.re && mdl.rd != 0 && iv && ((u1 && mdl.rd == ins[19:15]) || (u2 && mdl.rd == ins[24:20]));
    check("stall_o", 32'(stall_o), 32'(haz && !fl && !stl));
    check("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
    check("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
    st_seen = stall_o;
    if (fl) mdl = bubble(mdl);
    else if (!stl) mdl = (haz || !iv) ? bubble(mdl) : d;
    @(posedge clk);
    #1;
    cmp_out();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst_valid", 32'(id_valid), 0);
    check("rst_pc", pc_o, 0);
    check("rst_rs1", rs1_val_o, 0);
    check("rst_imm", imm_o, 0);
    check("rst_flags", {27'b0, rd_we, mem_re, mem_we, illegal, alu_src}, 0);
    mdl = '{default: 0};
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [6:0] opcs [11];
    logic [31:0] r;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
    inst = 0; inst_valid = 0; stall = 0; flush = 0; rs1_val = 0; rs2_val = 0;
    wb_we = 0; wb_addr = 0; wb_val = 0; pc = 0;
    mdl = '{default: 0};
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(id_valid), 0);
    check("reset_stall", 32'(stall_o), 0);
    rst = 0;
    // ADDI x5,x1,-1
    step(32'hFFF08293, 1, 0, 0, 7, 0, 0, 0, 0, 32'h100);
    check("addi_rs1", rs1_val_o, 7);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_rd", 32'(rd_addr), 5);
    check("addi_we", 32'(rd_we), 1);
    check("addi_src", 32'(alu_src), 1);
    // LW x3,0(x1) then ADD x4,x3,x2
    step(32'h0000A183, 1, 0, 0, 0, 0, 0, 0, 0, 32'h104);
    step(32'h00218233, 1, 0, 0, 1, 2, 0, 0, 0, 32'h108);
    check("lu_stall", 32'(st_seen), 1);
    check("lu_bubble", 32'(id_valid), 0);
    step(32'h00218233, 1, 0, 0, 1, 2, 0, 0, 0, 32'h108);
    check("lu_release", 32'(st_seen), 0);
    check("lu_issue", 32'(id_valid), 1);
    // ADD x6,x2,x0 with WB bypass of x2
    step(32'h00010333, 1, 0, 0, 32'h1111, 32'h2222, 1, 2, 32'hDEAD, 32'h10C);
    check("byp_rs1", rs1_val_o, 32'hDEAD);
    check("byp_rs2", rs2_val_o, 0);
    snap_pc = pc_o; snap_imm = imm_o;
    repeat (3) begin
      step(32'hFFF08293, 1, 1, 0, 9, 9, 0, 0, 0, 32'h200);
      check("hold_pc", pc_o, snap_pc);
      check("hold_rs1", rs1_val_o, 32'hDEAD);
    end
    step(32'hFFF08293, 1, 1, 1, 9, 9, 0, 0, 0, 32'h200);
    check("flush_stall", 32'(id_valid), 0);
    step(32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 32'h300);
    check("ill_flag", 32'(illegal), 1);
    check("ill_we", 32'(rd_we), 0);
    check("ill_valid", 32'(id_valid), 1);
    step(32'h00100013, 1, 0, 0, 0, 0, 0, 0, 0, 32'h304);
    check("x0_we", 32'(rd_we), 0);
    // reset while a load-use stall is pending
    step(32'h0000A183, 1, 0, 0, 0, 0, 0, 0, 0, 32'h400);
    step(32'h00218233, 1, 1, 0, 0, 0, 0, 0, 0, 32'h404);
    mid_reset();
    step(32'h00218233, 1, 0, 0, 3, 4, 0, 0, 0, 32'h404);
    check("rst_stall_clr", 32'(st_seen), 0);
    check("rst_issue", 32'(id_valid), 1);
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      r[6:0] = opcs[$urandom_range(0, 10)];
      r[11:7] = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      step(r, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6,
           $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom);
      if (k == 200) mid_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
